hpi_access_sequencer: RTL and testbench



---
 rtl/hpi_pkg.sv | 36 +++
 rtl/hpi_access_sequencer_if.sv | 20 ++
 rtl/hpi_rr_arbiter.sv | 36 +++
 rtl/hpi_access_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_hpi_access_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hpi_pkg.sv
// Shared types, register selects and default timing for the HPI access sequencer.
// The FSM state encodings live here so the bench and any wrapper agree on them.
package hpi_pkg;

  typedef enum logic [1:0] {
    HPI_ADDR_DATA    = 2'd0,
    HPI_ADDR_MAILBOX = 2'd1,
    HPI_ADDR_ADDRESS = 2'd2,
    HPI_ADDR_STATUS  = 2'd3
  } hpi_addr_e;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_TURN   = 3'd4;

  localparam int unsigned DEF_SETUP_CYC  = 1;
  localparam int unsigned DEF_STROBE_CYC = 4;
  localparam int unsigned DEF_HOLD_CYC   = 1;
  localparam int unsigned DEF_TURN_CYC   = 2;

  typedef struct packed {
    logic        port;
    logic        write;
    logic [1:0]  addr;
    logic [15:0] wdata;
  } req_t;

  // Down-counter preload for a phase of 'cyc' cycles; zero-length phases are skipped, never loaded.
  function automatic logic [3:0] cnt_load(input int unsigned cyc);
    if (cyc == 0) return 4'd0;
    return 4'(cyc - 1);
  endfunction

endpackage

// File: rtl/hpi_access_sequencer_if.sv
// Pad-side HPI bus between the sequencer (master) and the tri-state pad ring (slave).
interface hpi_access_sequencer_if;
  logic [1:0]  hpi_addr;
  logic        hpi_cs_n;
  logic        hpi_r_n;
  logic        hpi_w_n;
  logic [15:0] hpi_data_out;
  logic        hpi_data_oe;
  logic [15:0] hpi_data_in;

  modport master (
    output hpi_addr, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_out, hpi_data_oe,
    input  hpi_data_in
  );

  modport slave (
    input  hpi_addr, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_out, hpi_data_oe,
    output hpi_data_in
  );
endinterface

// File: rtl/hpi_rr_arbiter.sv
// Two-way round-robin arbiter. On a tie the port that did not win last time is granted;
// last_grant resets to 1 so port 0 wins the very first tie.
module hpi_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic last_q, last_d;

  always_comb begin
    gnt     = 2'b00;
    gnt_idx = 1'b0;
    last_d  = last_q;
    if (en) begin
      if (req[0] && (!req[1] || last_q)) begin
        gnt     = 2'b01;
        gnt_idx = 1'b0;
        last_d  = 1'b0;
      end else if (req[1]) begin
        gnt     = 2'b10;
        gnt_idx = 1'b1;
        last_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/hpi_access_sequencer.sv
// Shares the CY7C67200 HPI between the Nios bridge (port 0) and the keycode poller (port 1),
// issuing single-word cycles with programmable setup/strobe/hold/turnaround timing.
//
// state  | meaning
// IDLE   | bus released; grant a pending request
// SETUP  | CS_N low, address (and write data) valid ahead of the strobe
// STROBE | RD_N or WR_N low
// HOLD   | strobe released; CS_N, address and write data still held
// TURN   | CS_N high, data bus released before the next grant
module hpi_access_sequencer
  import hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
  parameter int unsigned TURN_CYC   = DEF_TURN_CYC
) (
  input  logic                   Clk,
  input  logic                   Reset,

  input  logic                   req0_valid,
  input  logic                   req0_write,
  input  logic [1:0]             req0_addr,
  input  logic [15:0]            req0_wdata,
  output logic                   req0_ready,
  output logic                   rsp0_valid,
  output logic [15:0]            rsp0_rdata,

  input  logic                   req1_valid,
  input  logic                   req1_write,
  input  logic [1:0]             req1_addr,
  input  logic [15:0]            req1_wdata,
  output logic                   req1_ready,
  output logic                   rsp1_valid,
  output logic [15:0]            rsp1_rdata,

  hpi_access_sequencer_if.master hpi,
  output logic                   busy
);

  localparam logic [2:0] ST_FIRST       = (SETUP_CYC != 0) ? ST_SETUP : ST_STROBE;
  localparam logic [2:0] ST_POST_HOLD   = (TURN_CYC != 0) ? ST_TURN : ST_IDLE;
  localparam logic [2:0] ST_POST_STROBE = (HOLD_CYC != 0) ? ST_HOLD : ST_POST_HOLD;

  localparam logic [3:0] SETUP_LD  = cnt_load(SETUP_CYC);
  localparam logic [3:0] STROBE_LD = cnt_load(STROBE_CYC);
  localparam logic [3:0] HOLD_LD   = cnt_load(HOLD_CYC);
  localparam logic [3:0] TURN_LD   = cnt_load(TURN_CYC);

  function automatic logic [3:0] load_for(input logic [2:0] st);
    case (st)
      ST_SETUP:  return SETUP_LD;
      ST_STROBE: return STROBE_LD;
      ST_HOLD:   return HOLD_LD;
      ST_TURN:   return TURN_LD;
      default:   return 4'd0;
    endcase
  endfunction

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        cs_n_q, cs_n_d;
  logic        r_n_q, r_n_d;
  logic        w_n_q, w_n_d;
  logic        oe_q, oe_d;
  logic [15:0] dout_q, dout_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;

  logic        arb_en;
  logic [1:0]  gnt;
  logic        gnt_idx;
  logic        accept;
  logic        strobe_done;
  logic        active_d;

  assign arb_en = (state_q == ST_IDLE) && !Reset;

  hpi_rr_arbiter u_arb (
    .clk     (Clk),
    .rst     (Reset),
    .en      (arb_en),
    .req     ({req1_valid, req0_valid}),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    accept      = 1'b0;
    strobe_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          accept      = 1'b1;
          req_d.port  = gnt_idx;
          req_d.write = gnt_idx ? req1_write : req0_write;
          req_d.addr  = gnt_idx ? req1_addr  : req0_addr;
          req_d.wdata = gnt_idx ? req1_wdata : req0_wdata;
          state_d     = ST_FIRST;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) state_d = ST_STROBE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          strobe_done = 1'b1;
          state_d     = ST_POST_STROBE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 4'd0) state_d = ST_POST_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_TURN: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) cnt_d = load_for(state_d);
  end

  // Pad controls are decoded from the next state so every strobe comes straight off a flop.
  always_comb begin
    active_d    = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    cs_n_d      = !active_d;
    r_n_d       = !((state_d == ST_STROBE) && !req_d.write);
    w_n_d       = !((state_d == ST_STROBE) && req_d.write);
    oe_d        = active_d && req_d.write;
    dout_d      = (accept && req_d.write) ? req_d.wdata : dout_q;
    rsp_valid_d = {strobe_done && req_q.port, strobe_done && !req_q.port};
    rdata0_d    = (strobe_done && !req_q.write && !req_q.port) ? hpi.hpi_data_in : rdata0_q;
    rdata1_d    = (strobe_done && !req_q.write &&  req_q.port) ? hpi.hpi_data_in : rdata1_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      req_q       <= '0;
      cs_n_q      <= 1'b1;
      r_n_q       <= 1'b1;
      w_n_q       <= 1'b1;
      oe_q        <= 1'b0;
      dout_q      <= 16'h0000;
      rsp_valid_q <= 2'b00;
      rdata0_q    <= 16'h0000;
      rdata1_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      cs_n_q      <= cs_n_d;
      r_n_q       <= r_n_d;
      w_n_q       <= w_n_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      rsp_valid_q <= rsp_valid_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign req0_ready       = gnt[0];
  assign req1_ready       = gnt[1];
  assign rsp0_valid       = rsp_valid_q[0];
  assign rsp1_valid       = rsp_valid_q[1];
  assign rsp0_rdata       = rdata0_q;
  assign rsp1_rdata       = rdata1_q;
  assign busy             = (state_q != ST_IDLE);

  assign hpi.hpi_addr     = req_q.addr;
  assign hpi.hpi_cs_n     = cs_n_q;
  assign hpi.hpi_r_n      = r_n_q;
  assign hpi.hpi_w_n      = w_n_q;
  assign hpi.hpi_data_out = dout_q;
  assign hpi.hpi_data_oe  = oe_q;

endmodule

// File: tb/tb_hpi_access_sequencer.sv
// Scoreboard bench for hpi_access_sequencer: a default-timing instance and a
// zero-setup/hold/turn instance, with responses checked by independent monitors.
module tb_hpi_access_sequencer;
  import hpi_pkg::*;

  typedef struct {
    int          port;
    int          cyc;
    logic [15:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_z;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_a[$];
  exp_t sb_z[$];
  logic [15:0] last_rd_a[2];
  logic [15:0] last_rd_z[2];

  logic a_req0_valid, a_req0_write, a_req0_ready, a_rsp0_valid;
  logic a_req1_valid, a_req1_write, a_req1_ready, a_rsp1_valid;
  logic [1:0]  a_req0_addr, a_req1_addr;
  logic [15:0] a_req0_wdata, a_req1_wdata, a_rsp0_rdata, a_rsp1_rdata;
  logic a_busy;

  logic z_req0_valid, z_req0_write, z_req0_ready, z_rsp0_valid;
  logic z_req1_valid, z_req1_write, z_req1_ready, z_rsp1_valid;
  logic [1:0]  z_req0_addr, z_req1_addr;
  logic [15:0] z_req0_wdata, z_req1_wdata, z_rsp0_rdata, z_rsp1_rdata;
  logic z_busy;

  hpi_access_sequencer_if hpi_a();
  hpi_access_sequencer_if hpi_z();

  hpi_access_sequencer dut_a (
    .Clk(clk), .Reset(rst_a),
    .req0_valid(a_req0_valid), .req0_write(a_req0_write), .req0_addr(a_req0_addr),
    .req0_wdata(a_req0_wdata), .req0_ready(a_req0_ready), .rsp0_valid(a_rsp0_valid),
    .rsp0_rdata(a_rsp0_rdata),
    .req1_valid(a_req1_valid), .req1_write(a_req1_write), .req1_addr(a_req1_addr),
    .req1_wdata(a_req1_wdata), .req1_ready(a_req1_ready), .rsp1_valid(a_rsp1_valid),
    .rsp1_rdata(a_rsp1_rdata),
    .hpi(hpi_a), .busy(a_busy)
  );

  hpi_access_sequencer #(.SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0), .TURN_CYC(0)) dut_z (
    .Clk(clk), .Reset(rst_z),
    .req0_valid(z_req0_valid), .req0_write(z_req0_write), .req0_addr(z_req0_addr),
    .req0_wdata(z_req0_wdata), .req0_ready(z_req0_ready), .rsp0_valid(z_rsp0_valid),
    .rsp0_rdata(z_rsp0_rdata),
    .req1_valid(z_req1_valid), .req1_write(z_req1_write), .req1_addr(z_req1_addr),
    .req1_wdata(z_req1_wdata), .req1_ready(z_req1_ready), .rsp1_valid(z_rsp1_valid),
    .rsp1_rdata(z_rsp1_rdata),
    .hpi(hpi_z), .busy(z_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic expect_rsp(input int inst, input int port, input bit is_read,
                            input logic [15:0] rd, input int at);
    exp_t e;
    e.port = port;
    e.cyc  = at;
    if (inst == 0) begin
      if (is_read) last_rd_a[port] = rd;
      e.rdata = last_rd_a[port];
      sb_a.push_back(e);
    end else begin
      if (is_read) last_rd_z[port] = rd;
      e.rdata = last_rd_z[port];
      sb_z.push_back(e);
    end
  endtask

  task automatic rsp_seen(input int inst, input int port, input logic [15:0] rd);
    exp_t e;
    int   depth;
    depth = (inst == 0) ? sb_a.size() : sb_z.size();
    if (depth == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL rsp_unexpected: inst %0d port %0d responded at cycle %0d, expected no response",
               inst, port, cyc);
      return;
    end
    if (inst == 0) e = sb_a.pop_front();
    else           e = sb_z.pop_front();
    chk("rsp_port", port, e.port);
    chk("rsp_cycle", cyc, e.cyc);
    chk("rsp_rdata", {16'b0, rd}, {16'b0, e.rdata});
  endtask

  always @(negedge clk) begin
    if (a_rsp0_valid) rsp_seen(0, 0, a_rsp0_rdata);
    if (a_rsp1_valid) rsp_seen(0, 1, a_rsp1_rdata);
    if (z_rsp0_valid) rsp_seen(1, 0, z_rsp0_rdata);
    if (z_rsp1_valid) rsp_seen(1, 1, z_rsp1_rdata);
  end

  function automatic logic rdy(input int inst, input int port);
    if (inst == 0) return (port == 0) ? a_req0_ready : a_req1_ready;
    return (port == 0) ? z_req0_ready : z_req1_ready;
  endfunction

  task automatic wait_ready(input int inst, input int port, output int t0);
    t0 = -1;
    for (int w = 0; w < 40; w++) begin
      @(negedge clk);
      if (rdy(inst, port)) begin
        t0 = cyc;
        break;
      end
    end
    if (t0 < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout: inst %0d port %0d no ready within 40 cycles, expected a ready pulse",
               inst, port);
    end
  endtask

  task automatic drain();
    for (int w = 0; w < 60 && (sb_a.size() != 0 || sb_z.size() != 0); w++) @(negedge clk);
    chk("sb_a_drained", sb_a.size(), 0);
    chk("sb_z_drained", sb_z.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  // Cycle-by-cycle pad waveform for one default-timing transaction accepted at cycle 0.
  task automatic wave_a(input bit write, input logic [1:0] addr, input logic [15:0] wd,
                        input bit pulse_in);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        a_req0_valid = 1'b0;
        a_req1_valid = 1'b0;
      end
      if (pulse_in) hpi_a.hpi_data_in = (k == 5) ? 16'hBEEF : 16'h0000;
      @(negedge clk);
      chkb("wave_cs_n", hpi_a.hpi_cs_n, !(k <= 6));
      chkb("wave_w_n", hpi_a.hpi_w_n, !(write && k >= 2 && k <= 5));
      chkb("wave_r_n", hpi_a.hpi_r_n, !(!write && k >= 2 && k <= 5));
      chkb("wave_oe", hpi_a.hpi_data_oe, write && (k <= 6));
      chkb("wave_busy", a_busy, k <= 8);
      if (k <= 6) chk("wave_addr", {30'b0, hpi_a.hpi_addr}, {30'b0, addr});
      if (write && k <= 6) chk("wave_dout", {16'b0, hpi_a.hpi_data_out}, {16'b0, wd});
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, prev, got;
    rst_a = 1'b1; rst_z = 1'b1;
    a_req0_valid = 0; a_req0_write = 0; a_req0_addr = 0; a_req0_wdata = 0;
    a_req1_valid = 0; a_req1_write = 0; a_req1_addr = 0; a_req1_wdata = 0;
    z_req0_valid = 0; z_req0_write = 0; z_req0_addr = 0; z_req0_wdata = 0;
    z_req1_valid = 0; z_req1_write = 0; z_req1_addr = 0; z_req1_wdata = 0;
    hpi_a.hpi_data_in = 16'h0000;
    hpi_z.hpi_data_in = 16'h0000;
    last_rd_a[0] = 0; last_rd_a[1] = 0; last_rd_z[0] = 0; last_rd_z[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_z = 1'b0;
    @(negedge clk);
    chkb("rst_cs_n", hpi_a.hpi_cs_n, 1'b1);
    chkb("rst_r_n", hpi_a.hpi_r_n, 1'b1);
    chkb("rst_w_n", hpi_a.hpi_w_n, 1'b1);
    chkb("rst_oe", hpi_a.hpi_data_oe, 1'b0);
    chkb("rst_busy", a_busy, 1'b0);
    chkb("rst_ready0", a_req0_ready, 1'b0);
    chkb("rst_rsp0", a_rsp0_valid, 1'b0);
    chk("rst_addr", {30'b0, hpi_a.hpi_addr}, 32'd0);
    chk("rst_dout", {16'b0, hpi_a.hpi_data_out}, 32'd0);
    chk("rst_rdata1", {16'b0, a_rsp1_rdata}, 32'd0);
    chkb("rst_z_cs_n", hpi_z.hpi_cs_n, 1'b1);
    chkb("rst_z_busy", z_busy, 1'b0);

    // port-0 write, addr 2
    @(posedge clk); #1;
    a_req0_write = 1; a_req0_addr = 2'd2; a_req0_wdata = 16'h1234; a_req0_valid = 1;
    wait_ready(0, 0, t0);
    chkb("wr_no_ready1", a_req1_ready, 1'b0);
    expect_rsp(0, 0, 0, 16'h0, t0 + 6);
    wave_a(1'b1, 2'd2, 16'h1234, 1'b0);
    drain();

    // port-1 read, addr 0, data valid only in the last strobe cycle
    @(posedge clk); #1;
    a_req1_write = 0; a_req1_addr = 2'd0; a_req1_valid = 1;
    wait_ready(0, 1, t0);
    expect_rsp(0, 1, 1, 16'hBEEF, t0 + 6);
    wave_a(1'b0, 2'd0, 16'h0000, 1'b1);
    drain();

    // both ports requesting continuously
    a_req0_write = 1; a_req0_addr = 2'd1; a_req0_wdata = 16'hA5A5;
    a_req1_write = 0; a_req1_addr = 2'd3;
    hpi_a.hpi_data_in = 16'h5A5A;
    @(posedge clk); #1;
    a_req0_valid = 1; a_req1_valid = 1;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      got = -1;
      for (int w = 0; w < 20; w++) begin
        @(negedge clk);
        if (a_req0_ready || a_req1_ready) begin
          chkb("rr_onehot", a_req0_ready & a_req1_ready, 1'b0);
          got = a_req1_ready ? 1 : 0;
          break;
        end
      end
      if (got < 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rr_timeout: no grant for transaction %0d, expected a grant", i);
        break;
      end
      chk("rr_grant", got, i % 2);
      if (prev >= 0) chk("rr_spacing", cyc - prev, 9);
      prev = cyc;
      expect_rsp(0, got, got == 1, 16'h5A5A, cyc + 6);
    end
    @(posedge clk); #1;
    a_req0_valid = 0; a_req1_valid = 0;
    drain();
    hpi_a.hpi_data_in = 16'h0000;

    // reset in the middle of a write
    @(posedge clk); #1;
    a_req0_write = 1; a_req0_addr = 2'd3; a_req0_wdata = 16'hCAFE; a_req0_valid = 1;
    wait_ready(0, 0, t0);
    @(posedge clk); #1; a_req0_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst_a = 1'b1;
    @(negedge clk);
    chkb("mid_w_n_active", hpi_a.hpi_w_n, 1'b0);
    @(posedge clk); #1; rst_a = 1'b0;
    last_rd_a[0] = 0; last_rd_a[1] = 0;
    @(negedge clk);
    chkb("mid_rst_cs_n", hpi_a.hpi_cs_n, 1'b1);
    chkb("mid_rst_w_n", hpi_a.hpi_w_n, 1'b1);
    chkb("mid_rst_oe", hpi_a.hpi_data_oe, 1'b0);
    chkb("mid_rst_busy", a_busy, 1'b0);
    chkb("mid_rst_rsp0", a_rsp0_valid, 1'b0);
    chk("mid_rst_addr", {30'b0, hpi_a.hpi_addr}, 32'd0);
    chk("mid_rst_dout", {16'b0, hpi_a.hpi_data_out}, 32'd0);
    chk("mid_rst_rdata1", {16'b0, a_rsp1_rdata}, 32'd0);
    repeat (10) @(negedge clk);

    // port 1 arrives while port 0 is in flight
    a_req0_write = 1; a_req0_addr = 2'd0; a_req0_wdata = 16'h4321;
    @(posedge clk); #1; a_req0_valid = 1;
    wait_ready(0, 0, t0);
    expect_rsp(0, 0, 0, 16'h0, t0 + 6);
    @(posedge clk); #1; a_req0_valid = 0;
    @(posedge clk); #1;
    a_req1_write = 0; a_req1_addr = 2'd1; hpi_a.hpi_data_in = 16'h0F0F; a_req1_valid = 1;
    wait_ready(0, 1, t1);
    chk("busy_wait_accept", t1 - t0, 9);
    expect_rsp(0, 1, 1, 16'h0F0F, t1 + 6);
    @(posedge clk); #1; a_req1_valid = 0;
    drain();

    // zero setup/hold/turn, single-cycle strobe: back-to-back writes
    @(posedge clk); #1;
    z_req0_write = 1; z_req0_addr = 2'd1; z_req0_wdata = 16'h1111; z_req0_valid = 1;
    wait_ready(1, 0, t0);
    expect_rsp(1, 0, 0, 16'h0, t0 + 2);
    @(posedge clk); #1; z_req0_wdata = 16'h2222;
    @(negedge clk);
    chkb("z_w_n_c1", hpi_z.hpi_w_n, 1'b0);
    chkb("z_cs_n_c1", hpi_z.hpi_cs_n, 1'b0);
    chkb("z_oe_c1", hpi_z.hpi_data_oe, 1'b1);
    chkb("z_busy_c1", z_busy, 1'b1);
    chk("z_dout_c1", {16'b0, hpi_z.hpi_data_out}, 32'h1111);
    @(negedge clk);
    chkb("z_ready_c2", z_req0_ready, 1'b1);
    chkb("z_w_n_c2", hpi_z.hpi_w_n, 1'b1);
    chkb("z_busy_c2", z_busy, 1'b0);
    expect_rsp(1, 0, 0, 16'h0, t0 + 4);
    @(posedge clk); #1; z_req0_valid = 0;
    @(negedge clk);
    chkb("z_w_n_c3", hpi_z.hpi_w_n, 1'b0);
    chk("z_dout_c3", {16'b0, hpi_z.hpi_data_out}, 32'h2222);
    @(negedge clk);
    chkb("z_busy_c4", z_busy, 1'b0);
    chkb("z_cs_n_c4", hpi_z.hpi_cs_n, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
